// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - cycle/event performance monitor with auto-stop, saturation and snapshot readout
module pipe_perf_monitor #(
    parameter int NUM_EVT = 2,
    parameter int CNT_W   = 32,
    parameter int LIMIT_W = 16,
    parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               limit_en_i,
    input  logic [LIMIT_W-1:0] limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    // Counter slot 0 is the cycle counter, slot k is event k-1.
    localparam int NCNT  = NUM_EVT + 1;
    // Limit and cycle count are compared at the wider of the two widths.
    localparam int CMP_W = (CNT_W > LIMIT_W) ? CNT_W : LIMIT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               count_en;
    logic [CNT_W-1:0]   cnt_q    [NCNT];
    logic [CNT_W-1:0]   shadow_q [NCNT];
    logic [NUM_EVT:0]   ovf_q;
    logic [NUM_EVT:0]   inc_en;
    logic [CNT_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cycle_next;
    logic [CMP_W-1:0]   cycle_ext;
    logic [CMP_W-1:0]   limit_ext;
    logic               limit_zero;

    // Saturating post-increment cycle value used by the limit compare.
    assign cycle_next = (cnt_q[0] == CNT_MAX) ? CNT_MAX : cnt_q[0] + CNT_W'(1);
    assign cycle_ext  = CMP_W'(cycle_next);
    assign limit_ext  = CMP_W'(limit_i);
    assign limit_zero = limit_en_i && (limit_i == '0);

    // The cycle slot increments on every counting edge; event slots only when strobed.
    assign inc_en = {evt_i, 1'b1} & {NCNT{count_en}};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and count enable; clear overrides everything, a zero limit stops before counting.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (limit_zero) begin
                    state_d = ST_DONE;
                end else if (!start_i) begin
                    state_d = ST_IDLE;
                end else begin
                    count_en = 1'b1;
                    // A limit already passed can only be caught once the counter pins at all ones.
                    if (limit_en_i && ((cycle_ext == limit_ext) || (cycle_next == CNT_MAX))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (clear_i) begin
            state_d  = ST_IDLE;
            count_en = 1'b0;
        end
    end

    // Live counters with saturation and sticky overflow flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                if (inc_en[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        ovf_q[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Shadow registers capture the pre-edge live counters on snap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (clear_i) begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (snap_i) begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= cnt_q[k];
            end
        end
    end

    // Registered readout of the selected shadow; out-of-range selects read zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else if (clear_i) begin
            rd_q <= '0;
        end else if (32'(rd_sel_i) < NCNT) begin
            rd_q <= shadow_q[rd_sel_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_data_o   = rd_q;
    assign cycle_cnt_o = cnt_q[0];
    assign running_o   = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - scoreboard bench for pipe_perf_monitor at 32-bit and 4-bit counter widths
module tb_pipe_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [1:0]  evt;
    logic        limit_en;
    logic [15:0] limit;
    logic        snap;
    logic [1:0]  rd_sel;

    logic [31:0] rd_a, cyc_a;
    logic        run_a, done_a;
    logic [2:0]  ovf_a;
    logic [3:0]  rd_b, cyc_b;
    logic        run_b, done_b;
    logic [2:0]  ovf_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(32), .LIMIT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .limit_en_i(limit_en), .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel),
        .rd_data_o(rd_a), .cycle_cnt_o(cyc_a), .running_o(run_a), .done_o(done_a), .ovf_o(ovf_a)
    );

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .LIMIT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .limit_en_i(limit_en), .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel),
        .rd_data_o(rd_b), .cycle_cnt_o(cyc_b), .running_o(run_b), .done_o(done_b), .ovf_o(ovf_b)
    );

    typedef struct {
        longint   rd;
        longint   cyc;
        bit       run;
        bit       done;
        bit [2:0] ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model: unbounded event totals; a visible counter is the total clipped to its maximum,
    // and an overflow flag means the total ever went beyond that maximum.
    int     m_state [2];   // 0 idle, 1 run, 2 done
    longint m_raw   [2][3];
    longint m_shd   [2][3];
    longint m_rd    [2];
    longint m_max   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clip(int i, longint v);
        return (v > m_max[i]) ? m_max[i] : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_rd[i] = 0;
            for (int k = 0; k < 3; k++) begin
                m_raw[i][k] = 0;
                m_shd[i][k] = 0;
            end
        end
    endtask

    task automatic model_step(int i);
        longint live[3];
        exp_t e;
        for (int k = 0; k < 3; k++) live[k] = clip(i, m_raw[i][k]);
        if (clear) begin
            model_clear_one(i);
        end else begin
            m_rd[i] = (rd_sel <= 2) ? m_shd[i][rd_sel] : 0;
            if (snap) for (int k = 0; k < 3; k++) m_shd[i][k] = live[k];
            if (m_state[i] == 0) begin
                if (start) m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (limit_en && limit == 0) begin
                    m_state[i] = 2;
                end else if (!start) begin
                    m_state[i] = 0;
                end else begin
                    m_raw[i][0] += 1;
                    m_raw[i][1] += evt[0];
                    m_raw[i][2] += evt[1];
                    if (limit_en && (clip(i, m_raw[i][0]) == longint'(limit) ||
                                     clip(i, m_raw[i][0]) == m_max[i]))
                        m_state[i] = 2;
                end
            end
        end
        e.rd   = m_rd[i];
        e.cyc  = clip(i, m_raw[i][0]);
        e.run  = (m_state[i] == 1);
        e.done = (m_state[i] == 2);
        e.ovf  = {m_raw[i][2] > m_max[i], m_raw[i][1] > m_max[i], m_raw[i][0] > m_max[i]};
        if (i == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic model_clear_one(int i);
        m_state[i] = 0;
        m_rd[i] = 0;
        for (int k = 0; k < 3; k++) begin
            m_raw[i][k] = 0;
            m_shd[i][k] = 0;
        end
    endtask

    // One clock: predict the post-edge outputs, then let the edge happen.
    task automatic step();
        model_step(0);
        model_step(1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rd_a"}, rd_a, 0);
        chk({tag, ".cyc_a"}, cyc_a, 0);
        chk({tag, ".run_a"}, run_a, 0);
        chk({tag, ".done_a"}, done_a, 0);
        chk({tag, ".ovf_a"}, ovf_a, 0);
        chk({tag, ".cyc_b"}, cyc_b, 0);
        chk({tag, ".ovf_b"}, ovf_b, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every negedge compares the DUT outputs against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a.rd", rd_a, e.rd);
            chk("a.cyc", cyc_a, e.cyc);
            chk("a.running", run_a, e.run);
            chk("a.done", done_a, e.done);
            chk("a.ovf", ovf_a, e.ovf);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b.rd", rd_b, e.rd);
            chk("b.cyc", cyc_b, e.cyc);
            chk("b.running", run_b, e.run);
            chk("b.done", done_b, e.done);
            chk("b.ovf", ovf_b, e.ovf);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 15;
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        evt = 2'b00;
        limit_en = 1'b0;
        limit = 16'd0;
        snap = 1'b0;
        rd_sel = 2'd0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Limit of 20 with an event every third RUN cycle.
        do_reset();
        start = 1'b1; limit_en = 1'b1; limit = 16'd20;
        for (int n = 0; n < 25; n++) begin
            evt = (n % 3 == 2) ? 2'b01 : 2'b00;
            step();
        end
        evt = 2'b00;
        chk("limit.cyc", cyc_a, 20);
        chk("limit.done", done_a, 1);
        chk("limit.running", run_a, 0);
        snap = 1'b1; step();
        snap = 1'b0; rd_sel = 2'd1; step();
        step();
        // Clear and snap together while in DONE.
        clear = 1'b1; snap = 1'b1; step();
        clear = 1'b0; snap = 1'b0; rd_sel = 2'd1; step();
        chk("clear.rd", rd_a, 0);
        start = 1'b0; step();

        // Pause and resume with both events held.
        do_reset();
        limit_en = 1'b0; evt = 2'b11; start = 1'b1;
        for (int n = 0; n < 6; n++) step();
        start = 1'b0;
        for (int n = 0; n < 4; n++) step();
        chk("pause.cyc", cyc_a, 5);
        start = 1'b1;
        for (int n = 0; n < 6; n++) step();
        chk("resume.cyc", cyc_a, 10);
        start = 1'b0; snap = 1'b1; step();
        snap = 1'b0; rd_sel = 2'd1; step();
        chk("resume.evt0", rd_a, 10);
        rd_sel = 2'd2; step();
        chk("resume.evt1", rd_a, 10);

        // Saturation of the narrow instance.
        do_reset();
        start = 1'b1; limit_en = 1'b0; evt = 2'b10;
        for (int n = 0; n < 21; n++) step();
        chk("sat.cyc_b", cyc_b, 15);
        chk("sat.ovf_b", ovf_b, 3'b101);
        chk("sat.cyc_a", cyc_a, 20);

        // Snapshot taken after 7 counted cycles.
        do_reset();
        start = 1'b1; rd_sel = 2'd0;
        for (int n = 0; n < 8; n++) begin
            evt = 2'($urandom);
            step();
        end
        snap = 1'b1; step();
        snap = 1'b0;
        step(); step();
        chk("snap.cyc", cyc_a, 10);
        rd_sel = 2'd0; step();
        chk("snap.rd0", rd_a, 7);
        rd_sel = 2'd3; step();
        chk("snap.rd3", rd_a, 0);

        // Zero limit goes straight to DONE, then reset mid-RUN.
        do_reset();
        limit_en = 1'b1; limit = 16'd0; start = 1'b1; evt = 2'b11;
        step(); step();
        chk("lim0.done", done_a, 1);
        chk("lim0.cyc", cyc_a, 0);
        limit_en = 1'b0; clear = 1'b1; step();
        clear = 1'b0;
        for (int n = 0; n < 4; n++) step();
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            start  = ($urandom % 8) != 0;
            clear  = ($urandom % 60) == 0;
            evt    = 2'($urandom);
            snap   = ($urandom % 10) == 0;
            rd_sel = 2'($urandom);
            if ($urandom % 50 == 0) limit_en = ~limit_en;
            if ($urandom % 50 == 0) limit = 16'($urandom % 48);
            step();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable performance monitor for the pipelined CPU. It counts clock cycles and a parametrised set of per-cycle event strobes, such as hazard-unit stall and IF flush. It stops automatically after a programmable cycle limit and exposes snapshot-consistent counter values through a registered read port. It sits beside the CPU top level, and its event inputs are tapped from the pipeline control signals.

## Interface
- NUM_EVT, default 2: number of event channels (>=1); channel 0 = stall, channel 1 = flush by convention.
- CNT_W, default 32: width of every counter (cycle and event).
- LIMIT_W, default 16: width of the cycle-limit value.
- SEL_W, default $clog2(NUM_EVT+1): width of the read select.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level; run enable.
- clear_i  in  1  synchronous clear of counters, flags and snapshots; returns the block to IDLE.
- evt_i  in  NUM_EVT  per-cycle event strobes; bit k increments event counter k.
- limit_en_i  in  1  enables automatic stop.
- limit_i  in  LIMIT_W  cycle limit.
- snap_i  in  1  capture all live counters into shadow registers.
- rd_sel_i  in  SEL_W  read select: 0 = cycle shadow, k = event k-1 shadow.
- rd_data_o  out  CNT_W  registered read data.
- cycle_cnt_o  out  CNT_W  live cycle counter.
- running_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- ovf_o  out  NUM_EVT+1  sticky saturation flags: bit 0 = cycle, bit k = event k-1.

## Operation
- State machine has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE with start_i=1 goes to RUN at the next edge. No counting happens on that edge.
- RUN with start_i=0 goes to IDLE (pause). All counters hold their values, and a later start_i=1 resumes counting.
- Counting happens on every edge taken while in RUN and not leaving RUN due to limit==0:
  - cycle counter += 1;
  - event counter k += evt_i[k].
- Limit: in RUN with limit_en_i=1, if the post-increment cycle count equals zero-extended limit_i, the block goes to DONE on that same edge.
- limit_en_i=1 with limit_i=0: the first RUN edge goes to DONE with no increment.
- If limit_en_i is set while the count is already at or above limit_i, the block does not stop until the counter saturates. It then goes to DONE.
- DONE holds all counters and ignores start_i and evt_i. Only clear_i or rst_i leaves DONE.
- Saturation: a counter at all ones stays at all ones and sets its ovf_o bit. The flag stays set until clear_i or rst_i.
- Snapshot: snap_i=1 copies the pre-edge values of every live counter into the shadows. snap_i works in any state.
- Readout: rd_data_o is loaded at each edge with shadow[rd_sel_i]. If rd_sel_i > NUM_EVT, rd_data_o is loaded with 0.
- Priority, highest first: rst_i, then clear_i, then limit/stop, then counting. snap_i is independent of counting; with clear_i it is overridden (shadows zeroed).
- clear_i zeroes all live counters, shadows, ovf_o and rd_data_o, and moves the block to IDLE regardless of state.

## Timing
- Reset values: state=IDLE, all counters=0, shadows=0, rd_data_o=0, cycle_cnt_o=0, running_o=0, done_o=0, ovf_o=0.
- running_o and done_o are decoded directly from the state register.
- cycle_cnt_o is the live register with no extra latency.
- Read latency is one cycle: rd_sel_i at edge n gives rd_data_o valid after edge n.
- Snapshot-to-read latency:
  - snap_i at edge n, then rd_sel_i at edge n+1: the data is visible after edge n+1.
  - rd_sel_i sampled at the same edge as snap_i returns the old shadow.
- Event strobes are sampled only at the rising edge. Multi-cycle pulses count once per cycle.
- rst_i asserted mid-RUN clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset, start_i=1, limit_en_i=1, limit_i=20, evt_i=2'b01 every 3rd RUN cycle → done_o rises on the 21st edge after start; cycle_cnt_o=20; event0 reads 6 or 7 according to the phase; running_o=0 thereafter.
- Pause and resume: run 5 cycles, start_i=0 for 4 cycles, run 5 more with evt_i=2'b11 → cycle=10, event0=10, event1=10; no counts while paused.
- Saturation with CNT_W=4, evt_i[1]=1 held for 20 RUN cycles, no limit → event1=15 and ovf_o[2]=1; cycle counter=15 and ovf_o[0]=1; ovf_o[1]=0 if evt_i[0]=0.
- Snapshot: after 7 cycles, pulse snap_i, then keep running 3 cycles and read sel 0 → rd_data_o=7 while cycle_cnt_o=10; sel=3 with NUM_EVT=2 → 0.
- Simultaneous clear_i and snap_i in DONE → state IDLE, all counters, shadows and ovf_o are 0; rd_data_o=0 next cycle.
- limit_en_i=1 with limit_i=0 → IDLE→RUN→DONE in two edges, cycle_cnt_o=0; rst_i pulse mid-RUN → all outputs 0 asynchronously.
